spi_sram_responder: RTL

// SPI-mode-0 serial-SRAM responder; answers READ (0x03) / WRITE (0x02) frames with a 16-bit byte address.

---
 rtl/spi_sram_responder_if.sv | 16 +
 rtl/spi_sram_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sram_responder_if.sv
// SPI bus bundle between an initiator (master) and the SRAM responder (slave).
//   SCK     : serial clock driven by the initiator
//   CS_N    : active-low chip select driven by the initiator
//   MOSI    : initiator data, MSB first
//   MISO    : responder data, MSB first
//   miso_oe : high while the responder is driving read data
interface spi_sram_responder_if;
  logic SCK;
  logic CS_N;
  logic MOSI;
  logic MISO;
  logic miso_oe;

  modport master (output SCK, output CS_N, output MOSI, input MISO, input miso_oe);
  modport slave  (input SCK, input CS_N, input MOSI, output MISO, output miso_oe);
endinterface

// File: rtl/spi_sram_responder.sv
// SPI mode-0 serial-SRAM responder backed by an on-chip byte array.
// Supported opcodes:
//   READ  (0x03) followed by a 16-bit address
//   WRITE (0x02) followed by a 16-bit address
// Both operations are sequential, and the address wraps modulo MEM_DEPTH.
// The SPI pins are oversampled in the clk domain, so no logic is clocked by SCK.
// Ports:
//   clk        : system clock, at least 8x the SCK frequency
//   reset      : synchronous, active-low
//   spi        : slave side of the SPI bundle (SCK, CS_N, MOSI in; MISO, miso_oe out)
//   frame_done : 1-clk pulse when CS_N rises after a frame that saw at least one SCK rise
//   bad_cmd    : 1-clk pulse when a completed opcode is neither READ nor WRITE
//   wr_count   : number of bytes committed by WRITE since reset (wraps)
module spi_sram_responder #(
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned SYNC_STG  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  spi_sram_responder_if.slave   spi,
  output logic                  frame_done,
  output logic                  bad_cmd,
  output logic [15:0]           wr_count
);

  localparam int unsigned AW       = $clog2(MEM_DEPTH);
  localparam int unsigned ARM_LAST = SYNC_STG + 1;
  localparam int unsigned ARM_W    = $clog2(SYNC_STG + 2);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, IGNORE} state_e;

  state_e            state_q, state_d;
  logic [SYNC_STG-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STG-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STG-1:0] mosi_sync_q, mosi_sync_d;
  logic              sck_prev_q, sck_prev_d;
  logic              cs_prev_q, cs_prev_d;
  logic [ARM_W-1:0]  arm_cnt_q, arm_cnt_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        rx_q, rx_d;
  logic [7:0]        tx_q, tx_d;
  logic [15:0]       addr_q, addr_d;
  logic              is_rd_q, is_rd_d;
  logic              load_pend_q, load_pend_d;
  logic              saw_rise_q, saw_rise_d;
  logic              frame_done_q, frame_done_d;
  logic              bad_cmd_q, bad_cmd_d;
  logic [15:0]       wr_count_q, wr_count_d;

  logic [7:0]        mem [0:MEM_DEPTH-1];
  logic [7:0]        rd_data_q;
  logic              mem_we;
  logic [AW-1:0]     mem_idx;
  logic [AW-1:0]     rd_idx;

  logic sck_s, cs_s, mosi_s, armed;
  logic sck_rise, sck_fall, cs_rise, cs_fall;
  logic [7:0] shift_in;

  // After reset the synchronizers hold their reset values for a few clocks.
  // Edge detection stays disarmed until real pin values have propagated, so
  // that a reset taken with CS_N low cannot be mistaken for a new frame start.
  always_comb begin
    sck_s    = sck_sync_q[SYNC_STG-1];
    cs_s     = cs_sync_q[SYNC_STG-1];
    mosi_s   = mosi_sync_q[SYNC_STG-1];
    armed    = (arm_cnt_q == ARM_W'(ARM_LAST));
    sck_rise = armed & ~cs_s &  sck_s & ~sck_prev_q;
    sck_fall = armed & ~cs_s & ~sck_s &  sck_prev_q;
    cs_rise  = armed &  cs_s & ~cs_prev_q;
    cs_fall  = armed & ~cs_s &  cs_prev_q;
    shift_in = {rx_q, mosi_s};

    sck_sync_d  = {sck_sync_q[SYNC_STG-2:0], spi.SCK};
    cs_sync_d   = {cs_sync_q[SYNC_STG-2:0], spi.CS_N};
    mosi_sync_d = {mosi_sync_q[SYNC_STG-2:0], spi.MOSI};
    sck_prev_d  = sck_s;
    cs_prev_d   = cs_s;
    arm_cnt_d   = armed ? arm_cnt_q : arm_cnt_q + ARM_W'(1);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      sck_sync_q   <= '0;
      cs_sync_q    <= '1;
      mosi_sync_q  <= '0;
      sck_prev_q   <= 1'b0;
      cs_prev_q    <= 1'b1;
      arm_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      rx_q         <= '0;
      tx_q         <= '0;
      addr_q       <= '0;
      is_rd_q      <= 1'b0;
      load_pend_q  <= 1'b0;
      saw_rise_q   <= 1'b0;
      frame_done_q <= 1'b0;
      bad_cmd_q    <= 1'b0;
      wr_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      sck_sync_q   <= sck_sync_d;
      cs_sync_q    <= cs_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      sck_prev_q   <= sck_prev_d;
      cs_prev_q    <= cs_prev_d;
      arm_cnt_q    <= arm_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_q         <= rx_d;
      tx_q         <= tx_d;
      addr_q       <= addr_d;
      is_rd_q      <= is_rd_d;
      load_pend_q  <= load_pend_d;
      saw_rise_q   <= saw_rise_d;
      frame_done_q <= frame_done_d;
      bad_cmd_q    <= bad_cmd_d;
      wr_count_q   <= wr_count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (cs_rise) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (cs_fall) state_d = CMD;
        CMD:     if (sck_rise && bit_cnt_q == 4'd7)
                   state_d = (shift_in == 8'h03 || shift_in == 8'h02) ? ADDR : IGNORE;
        ADDR:    if (sck_rise && bit_cnt_q == 4'd15)
                   state_d = is_rd_q ? RDATA : WDATA;
        default: state_d = state_q;
      endcase
    end
  end

  // Datapath next values
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    rx_d         = rx_q;
    tx_d         = tx_q;
    addr_d       = addr_q;
    is_rd_d      = is_rd_q;
    load_pend_d  = load_pend_q;
    saw_rise_d   = saw_rise_q;
    frame_done_d = 1'b0;
    bad_cmd_d    = 1'b0;
    wr_count_d   = wr_count_q;
    mem_we       = 1'b0;

    if (cs_rise) begin
      frame_done_d = saw_rise_q;
      saw_rise_d   = 1'b0;
      load_pend_d  = 1'b0;
      bit_cnt_d    = '0;
    end else begin
      if (cs_fall) begin
        bit_cnt_d  = '0;
        saw_rise_d = 1'b0;
      end
      if (sck_rise && state_q != IDLE) saw_rise_d = 1'b1;

      case (state_q)
        CMD: if (sck_rise) begin
          rx_d = shift_in[6:0];
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            if (shift_in == 8'h03)      is_rd_d = 1'b1;
            else if (shift_in == 8'h02) is_rd_d = 1'b0;
            else                        bad_cmd_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        ADDR: if (sck_rise) begin
          addr_d = {addr_q[14:0], mosi_s};
          if (bit_cnt_q == 4'd15) begin
            bit_cnt_d = '0;
            if (is_rd_q) begin
              load_pend_d = 1'b1;
              tx_d        = '0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        WDATA: if (sck_rise) begin
          rx_d = shift_in[6:0];
          if (bit_cnt_q == 4'd7) begin
            mem_we     = 1'b1;
            addr_d     = addr_q + 16'd1;
            wr_count_d = wr_count_q + 16'd1;
            bit_cnt_d  = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        RDATA: begin
          if (load_pend_q) begin
            tx_d        = rd_data_q;
            load_pend_d = 1'b0;
          end
          if (sck_rise && bit_cnt_q != 4'd8) bit_cnt_d = bit_cnt_q + 4'd1;
          // A fall before the first rise of a byte belongs to the last
          // address bit and must not disturb the freshly loaded MSB.
          if (sck_fall) begin
            if (bit_cnt_q == 4'd8) begin
              tx_d      = rd_data_q;
              addr_d    = addr_q + 16'd1;
              bit_cnt_d = '0;
            end else if (bit_cnt_q != 4'd0) begin
              tx_d = {tx_q[6:0], 1'b0};
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Single-port RAM. Outside the first load the read port prefetches the
  // byte after the one being shifted out, so it is ready at the byte boundary.
  always_comb begin
    rd_idx  = (state_q == RDATA && !load_pend_q) ? addr_q[AW-1:0] + AW'(1)
                                                 : addr_d[AW-1:0];
    mem_idx = mem_we ? addr_q[AW-1:0] : rd_idx;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= shift_in;
    rd_data_q <= mem[mem_idx];
  end

  // Output logic
  always_comb begin
    spi.miso_oe = (state_q == RDATA);
    spi.MISO    = (state_q == RDATA) & tx_q[7];
    frame_done  = frame_done_q;
    bad_cmd     = bad_cmd_q;
    wr_count    = wr_count_q;
  end

endmodule
